// File: rtl/led_scale_if.sv
// Frame handshake bundle for led_scale_pipe: input frame valid/ready and output frame valid/ready.
interface led_scale_if #(
  parameter int CH = 8,
  parameter int W  = 8
) ();
  logic          in_valid;
  logic          in_ready;
  logic [CH*W-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [CH*W-1:0] out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/led_scale_pipe.sv
// Multi-channel fractional-gain scaler, one channel per cycle through a shared multiplier.
// Optional `LED_SCALE_ROUND_NEAREST_EN selects round-half-up instead of truncation.
module led_scale_pipe #(
  parameter int CH       = 8,
  parameter int W        = 8,
  parameter int CW       = 9,
  parameter int FRAC     = 8,
  parameter int COEF_RST = 256
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          coef_we,
  input  logic [CW-1:0] coef_in,
  led_scale_if.slave    bus,
  output logic          busy
);
  localparam int IW = (CH > 1) ? $clog2(CH) : 1;
  localparam int PW = W + CW;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t          state, state_nx;
  logic [IW-1:0]   idx;
  logic [CH*W-1:0] in_lat;
  logic [CH*W-1:0] out_r;
  logic [CW-1:0]   coef_sh;
  logic [CW-1:0]   coef_act;
  logic            accept;
  logic [W-1:0]    x;
  logic [PW-1:0]   prod;
  logic [PW:0]     sum;
  logic [PW:0]     shr;
  logic [W-1:0]    y;

  assign accept        = (state == IDLE) && bus.in_valid;
  assign bus.in_ready  = (state == IDLE) && !rst;
  assign bus.out_valid = (state == DONE);
  assign bus.out_data  = out_r;
  assign busy          = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.in_valid) state_nx = CALC;
      CALC:    if (idx == IW'(CH - 1)) state_nx = DONE;
      DONE:    if (bus.out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    x    = in_lat[idx*W +: W];
    prod = {{CW{1'b0}}, x} * {{W{1'b0}}, coef_act};
`ifdef LED_SCALE_ROUND_NEAREST_EN
    sum  = {1'b0, prod} + ((PW+1)'(FRAC > 0 ? 1 : 0) << (FRAC > 0 ? FRAC - 1 : 0));
`else
    sum  = {1'b0, prod};
`endif
    shr  = sum >> FRAC;
    y    = (|shr[PW:W]) ? '1 : shr[W-1:0];
  end

  // Shadow write and accept on the same edge: NBA ordering hands the old shadow to the frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx      <= '0;
      in_lat   <= '0;
      out_r    <= '0;
      coef_sh  <= CW'(COEF_RST);
      coef_act <= CW'(COEF_RST);
    end else begin
      if (coef_we) coef_sh <= coef_in;
      if (accept) begin
        in_lat   <= bus.in_data;
        coef_act <= coef_sh;
        idx      <= '0;
      end
      if (state == CALC) begin
        out_r[idx*W +: W] <= y;
        idx <= (idx == IW'(CH - 1)) ? '0 : idx + 1'b1;
      end
    end
  end
endmodule
